player_controller: RTL

Player-motion stage directly downstream of the AI/gamepad button arbiter. It consumes `button_start`, `button_up` and `button_down` plus the collision `crash` flag, and runs the dino's run/jump/duck/dead state machine with frame-rate jump physics. It produces the player height used by the renderer and collision logic. It also drives `game_frozen`, which feeds back to the arbiter for auto-restart.

---
 rtl/player_controller.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/player_controller.sv
// Dino run/jump/duck/dead controller with frame-rate jump physics.
// Optional build macro PLAYER_FAST_FALL_EN doubles gravity in AIR while button_down is held.
module player_controller #(
    parameter int JUMP_VEL    = 8,
    parameter int GRAVITY     = 1,
    parameter int DEAD_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       button_start,
    input  logic       button_up,
    input  logic       button_down,
    input  logic       crash,
    output logic [7:0] player_height,
    output logic       jumping,
    output logic       ducking,
    output logic       game_frozen,
    output logic       jump_pulse,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_AIR  = 3'd2,
        S_DUCK = 3'd3,
        S_DEAD = 3'd4
    } state_t;

    localparam logic [7:0]        LAUNCH_H   = 8'(JUMP_VEL);
    localparam logic signed [7:0] LAUNCH_VEL = 8'(JUMP_VEL - GRAVITY);
    localparam logic signed [7:0] GRAV       = 8'(GRAVITY);
    localparam logic [7:0]        DEAD_MAX   = 8'(DEAD_FRAMES);

    state_t             r_state;
    logic [7:0]         r_height;
    logic signed [7:0]  r_vel;
    logic [7:0]         r_dead_cnt;
    logic               r_jumping;
    logic               r_ducking;
    logic               r_frozen;
    logic               r_jump_pulse;

    state_t             w_next_state;
    logic [7:0]         w_next_height;
    logic signed [7:0]  w_next_vel;
    logic [7:0]         w_next_cnt;
    logic               w_launch;
    logic signed [9:0]  w_sum;
    logic signed [7:0]  w_grav;
    logic [7:0]         w_cnt_inc;
    logic               w_crash_live;

    assign w_sum = $signed({2'b00, r_height}) + $signed({{2{r_vel[7]}}, r_vel});

`ifdef PLAYER_FAST_FALL_EN
    assign w_grav = button_down ? (GRAV <<< 1) : GRAV;
`else
    assign w_grav = GRAV;
`endif

    assign w_cnt_inc    = (r_dead_cnt >= DEAD_MAX) ? DEAD_MAX : r_dead_cnt + 8'd1;
    assign w_crash_live = crash && (r_state == S_RUN || r_state == S_AIR || r_state == S_DUCK);

    always_comb begin
        w_next_state  = r_state;
        w_next_height = r_height;
        w_next_vel    = r_vel;
        w_next_cnt    = r_dead_cnt;
        w_launch      = 1'b0;
        if (w_crash_live) begin
            // Height stays frozen at the crash point for the renderer.
            w_next_state = S_DEAD;
            w_next_cnt   = 8'd0;
        end else if (frame_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (button_start) begin
                        w_next_state  = S_RUN;
                        w_next_height = 8'd0;
                        w_next_vel    = 8'sd0;
                    end
                end
                S_RUN, S_DUCK: begin
                    if (button_up) begin
                        w_launch      = 1'b1;
                        w_next_state  = S_AIR;
                        w_next_height = LAUNCH_H;
                        w_next_vel    = LAUNCH_VEL;
                    end else if (button_down) begin
                        w_next_state = S_DUCK;
                    end else begin
                        w_next_state = S_RUN;
                    end
                end
                S_AIR: begin
                    if (w_sum <= 10'sd0) begin
                        w_next_height = 8'd0;
                        w_next_vel    = 8'sd0;
                        w_next_state  = button_down ? S_DUCK : S_RUN;
                    end else begin
                        w_next_height = (w_sum > 10'sd255) ? 8'hFF : w_sum[7:0];
                        w_next_vel    = r_vel - w_grav;
                    end
                end
                S_DEAD: begin
                    // The tick that brings the counter to DEAD_FRAMES is the first that may restart.
                    if (button_start && (w_cnt_inc == DEAD_MAX)) begin
                        w_next_state  = S_RUN;
                        w_next_height = 8'd0;
                        w_next_vel    = 8'sd0;
                        w_next_cnt    = 8'd0;
                    end else begin
                        w_next_cnt = w_cnt_inc;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_height     <= 8'd0;
            r_vel        <= 8'sd0;
            r_dead_cnt   <= 8'd0;
            r_jumping    <= 1'b0;
            r_ducking    <= 1'b0;
            r_frozen     <= 1'b1;
            r_jump_pulse <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_height     <= w_next_height;
            r_vel        <= w_next_vel;
            r_dead_cnt   <= w_next_cnt;
            r_jumping    <= (w_next_state == S_AIR);
            r_ducking    <= (w_next_state == S_DUCK);
            r_frozen     <= (w_next_state == S_IDLE) || (w_next_state == S_DEAD);
            r_jump_pulse <= w_launch;
        end
    end

    assign player_height = r_height;
    assign jumping       = r_jumping;
    assign ducking       = r_ducking;
    assign game_frozen   = r_frozen;
    assign jump_pulse    = r_jump_pulse;
    assign o_dbg_state   = r_state;

endmodule
